// File: rtl/router_pkg.sv
// Shared router definitions: default datapath sizes and a constant-evaluable
// log2 helper used to derive pointer widths.
package router_pkg;

    localparam int unsigned ROUTER_WIDTH_DEF      = 32;
    localparam int unsigned ROUTER_FIFO_DEPTH_DEF = 8;

    // Ceiling log2; returns 0 for values 0 and 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// DEPTH x WIDTH flop storage for the router input FIFO.
// Ports:
//   clk, reset  - clock; synchronous active-high reset (clears rd_data only)
//   wr_en       - write strobe, stores wr_data at wr_addr on the clock edge
//   wr_addr     - write address
//   wr_data     - write data
//   rd_en       - read strobe, loads rd_data from rd_addr on the clock edge
//   rd_addr     - read address
//   rd_data     - registered read data, holds when rd_en is low
module router_fifo_mem #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    // Storage is deliberately left out of reset; contents are only
    // meaningful between the FIFO pointers.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/router_in_fifo.sv
// Per-client input FIFO in front of the router controller. Sources write over
// a valid/ready handshake; the controller reads with pop and sees the word on
// data_out one clock later. All outputs come from registered state only.
// Ports:
//   clk, reset  - clock; synchronous active-high reset
//   in_valid    - source has a word on in_data
//   in_ready    - FIFO can accept a word this cycle (not full)
//   in_data     - source write data
//   pop         - read strobe from the router controller
//   empty       - no entries stored
//   data_out    - read data, valid the cycle after an accepted pop
//   almost_full - occupancy >= AFULL_LVL
//   count       - occupancy, 0..DEPTH
//   underflow   - sticky: pop seen while empty
//   overflow    - sticky: in_valid held while full
module router_in_fifo
    import router_pkg::*;
#(
    parameter int unsigned WIDTH     = ROUTER_WIDTH_DEF,
    parameter int unsigned DEPTH     = ROUTER_FIFO_DEPTH_DEF,
    parameter int unsigned AFULL_LVL = DEPTH - 2,
    parameter int unsigned ADDR_W    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              pop,
    output logic              empty,
    output logic [WIDTH-1:0]  data_out,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              underflow,
    output logic              overflow
);

    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W + 1)'(AFULL_LVL);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] count_d;
    logic            almost_full_q;
    logic            underflow_q;
    logic            overflow_q;
    logic            full;
    logic            push_acc;
    logic            pop_acc;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

    assign in_ready = !full;
    assign push_acc = in_valid && !full;
    assign pop_acc  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        count_d = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            almost_full_q <= 1'b0;
            underflow_q   <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            almost_full_q <= (count_d >= AFULL_CNT);
            underflow_q   <= underflow_q | (pop && empty);
            overflow_q    <= overflow_q | (in_valid && full);
        end
    end

    assign count       = wr_ptr_q - rd_ptr_q;
    assign almost_full = almost_full_q;
    assign underflow   = underflow_q;
    assign overflow    = overflow_q;

    // Read port is registered inside the memory, giving the 1-clock pop latency.
    // A word written this cycle cannot be read this cycle since empty and the
    // read address come from the pre-edge pointers.
    router_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_acc),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (in_data),
        .rd_en   (pop_acc),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (data_out)
    );

endmodule

// File: doc/router_in_fifo.md
Name: router_in_fifo

Overview:
- Per-client input FIFO that sits directly upstream of the multi-input router controller.
- Accepts traffic from a source over a valid/ready handshake and buffers it.
- Presents empty/pop/data to the router controller with a fixed 1-clock read latency: data appears the cycle after pop, matching router DELAY=1.
- One instance per client; tracks occupancy and flags protocol misuse.

Parameters:
- WIDTH, 32, data word width in bits
- DEPTH, 8, number of entries; power of two, >= 2
- AFULL_LVL, DEPTH-2, occupancy at or above which almost_full asserts
- ADDR_W, $clog2(DEPTH), derived pointer width; not overridden by users

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  source has a word on in_data
- in_ready  output  1  FIFO can accept a word this cycle
- in_data  input  WIDTH  source write data
- pop  input  1  read strobe from router controller (its gnt bit for this client)
- empty  output  1  no entries stored
- data_out  output  WIDTH  read data, valid the cycle after an accepted pop
- almost_full  output  1  count >= AFULL_LVL
- count  output  ADDR_W+1  current occupancy, 0..DEPTH
- underflow  output  1  sticky: pop seen while empty
- overflow  output  1  sticky: in_valid held while full (informational, not data loss)

Behaviour:
- Reset values (applied on the clk edge with reset high):
  - wr_ptr = rd_ptr = 0, count = 0
  - empty = 1, in_ready = 1, almost_full = 0
  - data_out = 0, underflow = 0, overflow = 0
- Reset mid-operation discards all contents. Storage array is not cleared.
- Pointers are ADDR_W+1 bits; the MSB is a wrap bit.
  - empty = (wr_ptr == rd_ptr)
  - full = ADDR_W LSBs equal and MSBs differ
  - All flags are derived from registered pointers: no combinational path from in_valid or pop to any output.
- in_ready = !full.
- push_acc = in_valid & in_ready. On push_acc, write mem[wr_ptr[ADDR_W-1:0]] = in_data and increment wr_ptr. Wrap is natural modulo 2*DEPTH.
- pop_acc = pop & !empty. On pop_acc, register data_out = mem[rd_ptr[ADDR_W-1:0]] and increment rd_ptr.
  - Latency: pop at cycle N gives the word on data_out at cycle N+1.
  - data_out holds its value when there is no pop_acc.
- pop while empty: ignored; pointers and data_out unchanged; underflow set, cleared only by reset.
- in_valid while full: no write; overflow set, cleared only by reset.
- Simultaneous push_acc and pop_acc: both take effect and count is unchanged.
  - When not empty, the popped word is the old head. A word written this cycle is never read in the same cycle (no bypass).
  - When full, in_ready = 0, so the pop proceeds alone and in_ready rises next cycle.
- Push into empty: empty deasserts the following cycle. First pop is possible at cycle N+1 and data appears at N+2.
- count = wr_ptr - rd_ptr, in ADDR_W+1 bits. almost_full is registered from the next-state count.
- Ordering is strict FIFO. No data reordering or loss under any legal sequence.

Decomposition:
- Shared package router_pkg:
  - ROUTER_WIDTH_DEF = 32
  - ROUTER_FIFO_DEPTH_DEF = 8
  - function clog2 for derived widths
- Sub-module router_fifo_mem: DEPTH x WIDTH flop array with one synchronous write port and one registered read port (read enable, address, registered data out). The FIFO top keeps the pointers, flags and sticky errors.

Test Plan:
- After reset, sample on cycle 1 -> empty=1, in_ready=1, count=0, data_out=0, underflow=0, overflow=0.
- Push 0xA0..0xA7 back-to-back (DEPTH=8), then pop 8 consecutive cycles -> in_ready=0 after the 8th push; data_out = 0xA0..0xA7 on the cycles after each pop; empty=1 after the last pop.
- With 8 entries held, drive in_valid=1 with 0xFF for 3 cycles, then drain -> overflow=1, count stays 8, 0xFF never appears on data_out.
- Pop with FIFO empty -> underflow=1, data_out keeps its previous value, rd_ptr unchanged; a subsequent push of 0x55 then pop returns 0x55.
- Hold count=4, push and pop every cycle for 20 cycles -> count stays 4, output order equals input order across pointer wrap, almost_full=0 (AFULL_LVL=6).
- Fill 5 entries, assert reset for 1 cycle, then push 0x11 and pop -> count=0 right after reset; data_out=0x11 (no stale data).
